// File: rtl/lcd_entry_buffer_pkg.sv
// Shared constants, key codes, state encoding and character helpers for the LCD entry buffer.
package entry_pkg;

    localparam int LINE_LEN = 16;
    localparam int LINE_W   = 8 * LINE_LEN;

    localparam logic [7:0] ASCII_BLANK  = 8'h20;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;
    localparam logic [7:0] ASCII_PLUS   = 8'h2B;
    localparam logic [7:0] ASCII_MINUS  = 8'h2D;
    localparam logic [7:0] ASCII_MUL    = 8'hD7;
    localparam logic [7:0] ASCII_DIV    = 8'h2F;
    localparam logic [7:0] ASCII_EQ     = 8'h3D;
    localparam logic [7:0] ASCII_CURSOR = 8'h5F;

    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MINUS = 4'd11;
    localparam logic [3:0] KEY_MUL   = 4'd12;
    localparam logic [3:0] KEY_DIV   = 4'd13;
    localparam logic [3:0] KEY_BACK  = 4'd14;
    localparam logic [3:0] KEY_CLEAR = 4'd15;

    localparam logic [4:0]        LEN_FULL   = 5'd16;
    localparam logic [LINE_W-1:0] BLANK_LINE = {LINE_LEN{ASCII_BLANK}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Character 0 sits in the MSBs of a packed line.
    function automatic logic [LINE_W-1:0] set_char(input logic [LINE_W-1:0] line,
                                                   input int pos, input logic [7:0] ch);
        logic [LINE_W-1:0] r;
        r = line;
        for (int k = 0; k < LINE_LEN; k++) begin
            if (k == pos) r[8*(LINE_LEN-1-k) +: 8] = ch;
        end
        return r;
    endfunction

    function automatic logic [7:0] get_char(input logic [LINE_W-1:0] line, input int pos);
        logic [7:0] r;
        r = ASCII_BLANK;
        for (int k = 0; k < LINE_LEN; k++) begin
            if (k == pos) r = line[8*(LINE_LEN-1-k) +: 8];
        end
        return r;
    endfunction

    function automatic logic is_op_char(input logic [7:0] ch);
        return (ch == ASCII_PLUS) || (ch == ASCII_MINUS) || (ch == ASCII_MUL) || (ch == ASCII_DIV);
    endfunction

    function automatic logic [7:0] key_ascii(input logic [3:0] code);
        logic [7:0] r;
        case (code)
            KEY_PLUS:  r = ASCII_PLUS;
            KEY_MINUS: r = ASCII_MINUS;
            KEY_MUL:   r = ASCII_MUL;
            KEY_DIV:   r = ASCII_DIV;
            default:   r = ASCII_ZERO + {4'b0000, code};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lcd_entry_buffer_if.sv
// Key/result inputs and LCD line outputs of the entry buffer, grouped as one bus.
interface lcd_entry_buffer_if;
    import entry_pkg::*;

    logic              i_key_valid;
    logic [3:0]        i_key_code;
    logic              i_result_valid;
    logic [15:0]       i_result;
    logic [LINE_W-1:0] o_line1;
    logic [LINE_W-1:0] o_line2;
    logic [4:0]        o_len;
    logic              o_busy;
    logic              o_full;
    logic              o_drop;
    logic              o_lcd_update;

    modport master (
        output i_key_valid, i_key_code, i_result_valid, i_result,
        input  o_line1, o_line2, o_len, o_busy, o_full, o_drop, o_lcd_update
    );

    modport slave (
        input  i_key_valid, i_key_code, i_result_valid, i_result,
        output o_line1, o_line2, o_len, o_busy, o_full, o_drop, o_lcd_update
    );

endinterface

// File: rtl/lcd_entry_buffer_bin2bcd.sv
// Iterative double-dabble: 16-bit binary to 5 BCD digits, one shift per cycle.
// The first shift happens on the start edge, so o_done pulses 16 cycles after i_start.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [15:0] i_value,
    output logic        o_done,
    output logic [19:0] o_bcd
);

    logic [35:0] sr_q, sr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    function automatic logic [35:0] dd_step(input logic [35:0] sr);
        logic [35:0] t;
        t = sr;
        for (int n = 0; n < 5; n++) begin
            if (t[16+4*n +: 4] >= 4'd5) t[16+4*n +: 4] = t[16+4*n +: 4] + 4'd3;
        end
        return {t[34:0], 1'b0};
    endfunction

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (i_start) begin
            sr_d  = dd_step({20'b0, i_value});
            cnt_d = 5'd15;
        end else if (cnt_q != 5'd0) begin
            sr_d   = dd_step(sr_q);
            cnt_d  = cnt_q - 5'd1;
            done_d = (cnt_q == 5'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign o_done = done_q;
    assign o_bcd  = sr_q[35:16];

endmodule

// File: rtl/lcd_entry_buffer.sv
// Calculator LCD entry buffer: key edits build line 1, ALU results are written to line 2.
// Optional ENTRY_CURSOR_EN shows '_' at line1[len] while the line is not full.
//
//   state    | meaning
//   ST_IDLE  | accepting key edits and result strobes
//   ST_CONV  | binary-to-BCD conversion running, events dropped
//   ST_WRITE | formatted result written to line 2 on exit
module lcd_entry_buffer
    import entry_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    lcd_entry_buffer_if.slave bus
);

    state_e            state_q, state_d;
    logic [LINE_W-1:0] line1_q, line1_d;
    logic [LINE_W-1:0] line2_q, line2_d;
    logic [4:0]        len_q, len_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;
    logic              update_q, update_d;

    logic              conv_start;
    logic              conv_done;
    logic [19:0]       conv_bcd;
    logic [LINE_W-1:0] line2_fmt;
    logic [LINE_W-1:0] line1_vis;
    logic [7:0]        key_char;
    logic [3:0]        digit;
    logic              lead;
    int                len_i;

    assign len_i    = int'(len_q);
    assign key_char = key_ascii(bus.i_key_code);

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .i_start (conv_start),
        .i_value (bus.i_result),
        .o_done  (conv_done),
        .o_bcd   (conv_bcd)
    );

    // '=' in column 0, digits right-aligned to column 15, leading zeros blanked.
    always_comb begin
        line2_fmt = set_char(BLANK_LINE, 0, ASCII_EQ);
        lead      = 1'b1;
        digit     = 4'd0;
        for (int i = 4; i >= 1; i--) begin
            digit = conv_bcd[4*i +: 4];
            if (!(lead && digit == 4'd0)) begin
                lead      = 1'b0;
                line2_fmt = set_char(line2_fmt, LINE_LEN-1-i, ASCII_ZERO + {4'b0000, digit});
            end
        end
        line2_fmt = set_char(line2_fmt, LINE_LEN-1, ASCII_ZERO + {4'b0000, conv_bcd[3:0]});
    end

    always_comb begin
        state_d    = state_q;
        line1_d    = line1_q;
        line2_d    = line2_q;
        len_d      = len_q;
        drop_d     = 1'b0;
        conv_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_result_valid) begin
                    conv_start = 1'b1;
                    state_d    = ST_CONV;
                    drop_d     = bus.i_key_valid;
                end else if (bus.i_key_valid) begin
                    case (bus.i_key_code)
                        KEY_CLEAR: begin
                            line1_d = BLANK_LINE;
                            line2_d = BLANK_LINE;
                            len_d   = 5'd0;
                        end
                        KEY_BACK: begin
                            if (len_q != 5'd0) begin
                                line1_d = set_char(line1_q, len_i - 1, ASCII_BLANK);
                                len_d   = len_q - 5'd1;
                            end
                        end
                        KEY_PLUS, KEY_MINUS, KEY_MUL, KEY_DIV: begin
                            if (len_q == 5'd0) begin
                                drop_d = 1'b1;
                            end else if (is_op_char(get_char(line1_q, len_i - 1))) begin
                                line1_d = set_char(line1_q, len_i - 1, key_char);
                            end else if (len_q != LEN_FULL) begin
                                line1_d = set_char(line1_q, len_i, key_char);
                                len_d   = len_q + 5'd1;
                            end else begin
                                drop_d = 1'b1;
                            end
                        end
                        default: begin
                            if (len_q != LEN_FULL) begin
                                line1_d = set_char(line1_q, len_i, key_char);
                                len_d   = len_q + 5'd1;
                            end else begin
                                drop_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_CONV: begin
                if (conv_done) state_d = ST_WRITE;
                drop_d = bus.i_key_valid | bus.i_result_valid;
            end
            ST_WRITE: begin
                line2_d = line2_fmt;
                state_d = ST_IDLE;
                drop_d  = bus.i_key_valid | bus.i_result_valid;
            end
            default: state_d = ST_IDLE;
        endcase
        // Only a visible change raises the update strobe; cursor position follows len.
        update_d = (line1_d != line1_q) || (line2_d != line2_q) || (len_d != len_q);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            line1_q  <= BLANK_LINE;
            line2_q  <= BLANK_LINE;
            len_q    <= 5'd0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            line1_q  <= line1_d;
            line2_q  <= line2_d;
            len_q    <= len_d;
            busy_q   <= busy_d;
            drop_q   <= drop_d;
            update_q <= update_d;
        end
    end

    always_comb begin
        line1_vis = line1_q;
`ifdef ENTRY_CURSOR_EN
        if (len_q != LEN_FULL) line1_vis = set_char(line1_q, len_i, ASCII_CURSOR);
`endif
    end

    assign bus.o_line1      = line1_vis;
    assign bus.o_line2      = line2_q;
    assign bus.o_len        = len_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_full       = (len_q == LEN_FULL);
    assign bus.o_drop       = drop_q;
    assign bus.o_lcd_update = update_q;

endmodule

// File: tb/tb_lcd_entry_buffer.sv
// Scoreboarded bench for lcd_entry_buffer: key edits, result formatting, busy drops and reset abort.
module tb_lcd_entry_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    typedef logic [262:0] snap_t;
    localparam logic [127:0] BLANKS = {16{8'h20}};

    byte unsigned m_chars [16];
    int           m_len;
    logic [127:0] m_line2;
    snap_t        exp_q [$];
    logic [127:0] res_q [$];

    always #5 clk = ~clk;

    lcd_entry_buffer_if bus ();
    lcd_entry_buffer dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [127:0] str16(input string s);
        logic [127:0] r;
        r = BLANKS;
        for (int k = 0; k < 16; k++) if (k < s.len()) r[8*(15-k) +: 8] = s[k];
        return r;
    endfunction

    function automatic logic [127:0] model_line1();
        logic [127:0] r;
        for (int k = 0; k < 16; k++) begin
            r[8*(15-k) +: 8] = m_chars[k];
`ifdef ENTRY_CURSOR_EN
            if (k == m_len) r[8*(15-k) +: 8] = 8'h5F;
`endif
        end
        return r;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 16; k++) m_chars[k] = 8'h20;
        m_len   = 0;
        m_line2 = BLANKS;
    endfunction

    function automatic bit ch_is_op(input byte unsigned c);
        return (c == 8'h2B) || (c == 8'h2D) || (c == 8'hD7) || (c == 8'h2F);
    endfunction

    function automatic void model_key(input int code, output bit u, output bit d);
        byte unsigned ch;
        u = 1'b0;
        d = 1'b0;
        case (code)
            10: ch = 8'h2B;
            11: ch = 8'h2D;
            12: ch = 8'hD7;
            13: ch = 8'h2F;
            default: ch = 8'(8'h30 + code);
        endcase
        if (code == 15) begin
            u = (m_len != 0) || (m_line2 !== BLANKS);
            model_reset();
        end else if (code == 14) begin
            if (m_len > 0) begin
                m_len--;
                m_chars[m_len] = 8'h20;
                u = 1'b1;
            end
        end else if (code >= 10 && m_len == 0) begin
            d = 1'b1;
        end else if (code >= 10 && ch_is_op(m_chars[m_len-1])) begin
            u = (m_chars[m_len-1] != ch);
            m_chars[m_len-1] = ch;
        end else if (m_len < 16) begin
            m_chars[m_len] = ch;
            m_len++;
            u = 1'b1;
        end else begin
            d = 1'b1;
        end
    endfunction

    function automatic snap_t expect_now(input bit u, input bit d);
        return {model_line1(), m_line2, 5'(m_len), u, d};
    endfunction

    function automatic snap_t observe();
        return {bus.o_line1, bus.o_line2, bus.o_len, bus.o_lcd_update, bus.o_drop};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int code);
        bit u, d;
        model_key(code, u, d);
        exp_q.push_back(expect_now(u, d));
        bus.i_key_valid = 1'b1;
        bus.i_key_code  = 4'(code);
        step();
        bus.i_key_valid = 1'b0;
    endtask

    task automatic send_result(input int v);
        res_q.push_back(str16($sformatf("=%15d", v)));
        bus.i_result       = 16'(v);
        bus.i_result_valid = 1'b1;
        step();
        bus.i_result_valid = 1'b0;
    endtask

    // Observation only: cycle index of the update pulse and busy-level deviations on the way.
    task automatic wait_update(input int start_c, output int upd_at, output int busy_err);
        upd_at   = -1;
        busy_err = 0;
        for (int c = start_c; c <= start_c + 40; c++) begin
            if (bus.o_busy !== ((c <= 17) ? 1'b1 : 1'b0)) busy_err++;
            if (bus.o_lcd_update === 1'b1) begin
                upd_at = c;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        model_reset();
        total++;
        if (observe() !== expect_now(0, 0)) begin
            bad++;
            $display("FAIL reset_state act=%h req=%h", observe(), expect_now(0, 0));
        end
        total++;
        if ({bus.o_busy, bus.o_full} !== 2'b00) begin
            bad++;
            $display("FAIL reset_busy_full act=%b req=00", {bus.o_busy, bus.o_full});
        end
        rst = 1'b0;
        step();
        total++;
        if (observe() !== expect_now(0, 0)) begin
            bad++;
            $display("FAIL idle_after_reset act=%h req=%h", observe(), expect_now(0, 0));
        end
    endtask

    task automatic test_keys();
        int    keys [$] = '{1, 10, 2};
        int    ups = 0;
        snap_t e;
        for (int i = 0; i < keys.size(); i++) begin
            press(keys[i]);
            ups += int'(bus.o_lcd_update);
            e = exp_q.pop_front();
            total++;
            if (observe() !== e) begin
                bad++;
                $display("FAIL keys code=%0d act=%h req=%h", keys[i], observe(), e);
            end
        end
        total++;
        if (ups != 3) begin
            bad++;
            $display("FAIL keys_update_count act=%0d req=3", ups);
        end
        total++;
        if (bus.o_line1[127:104] !== "1+2" || bus.o_len !== 5'd3) begin
            bad++;
            $display("FAIL keys_text act=%h/%0d req=%h/3", bus.o_line1[127:104], bus.o_len, "1+2");
        end
    endtask

    task automatic test_op_replace();
        int    keys [$] = '{10, 11, 15, 12, 1, 10, 10};
        snap_t e;
        for (int i = 0; i < keys.size(); i++) begin
            press(keys[i]);
            e = exp_q.pop_front();
            total++;
            if (observe() !== e) begin
                bad++;
                $display("FAIL op_replace step=%0d code=%0d act=%h req=%h", i, keys[i], observe(), e);
            end
            if (i == 1) begin
                total++;
                if (bus.o_line1[127:96] !== "1+2-" || bus.o_len !== 5'd4) begin
                    bad++;
                    $display("FAIL op_replace_text act=%h/%0d req=%h/4", bus.o_line1[127:96], bus.o_len, "1+2-");
                end
            end
        end
    endtask

    task automatic test_full();
        snap_t e;
        int    keys [$];
        keys.push_back(15);
        for (int i = 0; i < 16; i++) keys.push_back(i % 10);
        keys.push_back(7);
        keys.push_back(10);
        for (int i = 0; i < keys.size(); i++) begin
            press(keys[i]);
            e = exp_q.pop_front();
            total++;
            if (observe() !== e) begin
                bad++;
                $display("FAIL full step=%0d code=%0d act=%h req=%h", i, keys[i], observe(), e);
            end
        end
        total++;
        if (bus.o_full !== 1'b1) begin
            bad++;
            $display("FAIL full_level act=%b req=1", bus.o_full);
        end
        press(14);
        e = exp_q.pop_front();
        total++;
        if (observe() !== e || bus.o_full !== 1'b0) begin
            bad++;
            $display("FAIL full_backspace act=%h full=%b req=%h full=0", observe(), bus.o_full, e);
        end
    endtask

    task automatic test_result();
        int           vals [$] = '{12345, 0, 65535, 100};
        int           keys [$] = '{15, 4, 10};
        int           upd_at, busy_err;
        snap_t        e;
        logic [127:0] exp2;
        for (int i = 0; i < keys.size(); i++) begin
            press(keys[i]);
            e = exp_q.pop_front();
            total++;
            if (observe() !== e) begin
                bad++;
                $display("FAIL result_setup code=%0d act=%h req=%h", keys[i], observe(), e);
            end
        end
        for (int i = 0; i < vals.size(); i++) begin
            send_result(vals[i]);
            wait_update(1, upd_at, busy_err);
            exp2    = res_q.pop_front();
            m_line2 = exp2;
            total++;
            if (upd_at != 18 || busy_err != 0) begin
                bad++;
                $display("FAIL result_timing v=%0d act=upd@%0d busyerr=%0d req=upd@18 busyerr=0", vals[i], upd_at, busy_err);
            end
            total++;
            if (bus.o_line2 !== exp2) begin
                bad++;
                $display("FAIL result_line2 v=%0d act=%h req=%h", vals[i], bus.o_line2, exp2);
            end
            total++;
            if (bus.o_line1 !== model_line1() || bus.o_len !== 5'(m_len)) begin
                bad++;
                $display("FAIL result_line1_kept v=%0d act=%h req=%h", vals[i], bus.o_line1, model_line1());
            end
        end
    endtask

    task automatic test_busy_drop();
        int           upd_at, busy_err;
        logic [127:0] exp2;
        send_result(777);
        step();
        step();
        bus.i_result       = 16'd5;
        bus.i_result_valid = 1'b1;
        step();
        bus.i_result_valid = 1'b0;
        total++;
        if (bus.o_drop !== 1'b1) begin
            bad++;
            $display("FAIL busy_result_drop act=%b req=1", bus.o_drop);
        end
        step();
        bus.i_key_valid = 1'b1;
        bus.i_key_code  = 4'd3;
        step();
        bus.i_key_valid = 1'b0;
        total++;
        if (bus.o_drop !== 1'b1 || bus.o_busy !== 1'b1 || bus.o_line1 !== model_line1()) begin
            bad++;
            $display("FAIL busy_key_drop act=drop%b busy%b %h req=drop1 busy1 %h", bus.o_drop, bus.o_busy, bus.o_line1, model_line1());
        end
        wait_update(6, upd_at, busy_err);
        exp2    = res_q.pop_front();
        m_line2 = exp2;
        total++;
        if (upd_at != 18 || busy_err != 0 || bus.o_line2 !== exp2) begin
            bad++;
            $display("FAIL busy_result_kept act=upd@%0d busyerr=%0d %h req=upd@18 busyerr=0 %h", upd_at, busy_err, bus.o_line2, exp2);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        bus.i_result       = 16'd4321;
        bus.i_result_valid = 1'b1;
        step();
        bus.i_result_valid = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        total++;
        if (observe() !== expect_now(0, 0) || bus.o_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_state act=%h busy=%b req=%h busy=0", observe(), bus.o_busy, expect_now(0, 0));
        end
        for (int c = 0; c < 25; c++) begin
            step();
            if (bus.o_lcd_update === 1'b1 || bus.o_busy === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL reset_mid_quiet act=%0d req=0", pulses);
        end
    endtask

    task automatic test_backspace();
        int           keys_a [$] = '{1, 2, 3, 14};
        int           keys_b [$] = '{15, 14};
        int           upd_at, busy_err;
        snap_t        e;
        logic [127:0] exp2;
        for (int i = 0; i < keys_a.size(); i++) begin
            press(keys_a[i]);
            e = exp_q.pop_front();
            total++;
            if (observe() !== e) begin
                bad++;
                $display("FAIL backspace code=%0d act=%h req=%h", keys_a[i], observe(), e);
            end
        end
        total++;
        if (bus.o_len !== 5'd2) begin
            bad++;
            $display("FAIL backspace_len act=%0d req=2", bus.o_len);
        end
        send_result(9);
        wait_update(1, upd_at, busy_err);
        exp2    = res_q.pop_front();
        m_line2 = exp2;
        total++;
        if (upd_at != 18 || bus.o_line2 !== exp2) begin
            bad++;
            $display("FAIL result_single act=upd@%0d %h req=upd@18 %h", upd_at, bus.o_line2, exp2);
        end
        for (int i = 0; i < keys_b.size(); i++) begin
            press(keys_b[i]);
            e = exp_q.pop_front();
            total++;
            if (observe() !== e) begin
                bad++;
                $display("FAIL clear_backspace code=%0d act=%h req=%h", keys_b[i], observe(), e);
            end
        end
        total++;
        if (bus.o_line2 !== BLANKS || bus.o_len !== 5'd0) begin
            bad++;
            $display("FAIL clear_blank act=%h len=%0d req=%h len=0", bus.o_line2, bus.o_len, BLANKS);
        end
    endtask

    task automatic test_back_to_back();
        int           upd_at, busy_err;
        logic [127:0] exp2;
        press(8);
        void'(exp_q.pop_front());
        send_result(111);
        wait_update(1, upd_at, busy_err);
        exp2    = res_q.pop_front();
        m_line2 = exp2;
        total++;
        if (upd_at != 18 || bus.o_line2 !== exp2) begin
            bad++;
            $display("FAIL b2b_first act=upd@%0d %h req=upd@18 %h", upd_at, bus.o_line2, exp2);
        end
        bus.i_key_valid = 1'b1;
        bus.i_key_code  = 4'd5;
        send_result(222);
        bus.i_key_valid = 1'b0;
        total++;
        if (bus.o_drop !== 1'b1 || bus.o_busy !== 1'b1 || bus.o_line1 !== model_line1()) begin
            bad++;
            $display("FAIL b2b_key_lost act=drop%b busy%b %h req=drop1 busy1 %h", bus.o_drop, bus.o_busy, bus.o_line1, model_line1());
        end
        wait_update(1, upd_at, busy_err);
        exp2    = res_q.pop_front();
        m_line2 = exp2;
        total++;
        if (upd_at != 18 || busy_err != 0 || bus.o_line2 !== exp2) begin
            bad++;
            $display("FAIL b2b_second act=upd@%0d busyerr=%0d %h req=upd@18 busyerr=0 %h", upd_at, busy_err, bus.o_line2, exp2);
        end
    endtask

    initial begin
        bus.i_key_valid    = 1'b0;
        bus.i_key_code     = 4'd0;
        bus.i_result_valid = 1'b0;
        bus.i_result       = 16'd0;
        test_reset();
        test_keys();
        test_op_replace();
        test_full();
        test_result();
        test_busy_drop();
        test_reset_mid();
        test_backspace();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
